// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    localparam int          DIV_ITERS = 32;
    localparam int          CNT_W     = 5;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_iter (
    input  logic [31:0] rem_in,
    input  logic [31:0] quot_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic [31:0] quot_out
);

    logic [32:0] trial;
    logic [32:0] diff;

    // rem_in < divisor always holds, so a set borrow bit means "does not fit".
    always_comb begin
        trial = {rem_in, quot_in[31]};
        diff  = trial - {1'b0, divisor};
        if (!diff[32]) begin
            rem_out  = diff[31:0];
            quot_out = {quot_in[30:0], 1'b1};
        end else begin
            rem_out  = trial[31:0];
            quot_out = {quot_in[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: fixed-latency multiply, 32-step restoring divide, mthi/mtlo/mfhi/mflo,
// and the stall that holds ID while a HI/LO access would collide with a running op.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mult,
    input  logic        multu,
    input  logic        div,
    input  logic        divu,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [31:0]        op_a, op_a_nx;
    logic [31:0]        op_b, op_b_nx;
    logic [31:0]        rem, rem_nx;
    logic [31:0]        hi_nx, lo_nx;
    logic               busy_nx;
    logic               mul_signed, mul_signed_nx;
    logic               qneg, qneg_nx;
    logic               rneg, rneg_nx;
    logic               touch, accept;
    logic [31:0]        step_rem, step_quot;
    logic [63:0]        mul_x, mul_y, product;

    assign touch  = mult | multu | div | divu | mthi | mtlo | mfhi | mflo;
    assign stall  = busy & touch;
    assign accept = en & touch & ~stall;
    assign rdata  = mfhi ? hi : (mflo ? lo : 32'h0);

    // During DIV, op_a doubles as the quotient shift register and op_b as the divisor.
    div_iter u_div_iter (
        .rem_in   (rem),
        .quot_in  (op_a),
        .divisor  (op_b),
        .rem_out  (step_rem),
        .quot_out (step_quot)
    );

    assign mul_x   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'h0, op_a};
    assign mul_y   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'h0, op_b};
    assign product = mul_x * mul_y;

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        op_a_nx       = op_a;
        op_b_nx       = op_b;
        rem_nx        = rem;
        hi_nx         = hi;
        lo_nx         = lo;
        busy_nx       = busy;
        mul_signed_nx = mul_signed;
        qneg_nx       = qneg;
        rneg_nx       = rneg;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (mthi) hi_nx = a;
                    if (mtlo) lo_nx = a;
                    if (mult | multu) begin
                        state_nx      = MUL;
                        op_a_nx       = a;
                        op_b_nx       = b;
                        mul_signed_nx = mult;
                        busy_nx       = 1'b1;
                        cnt_nx        = CNT_W'(MUL_LAT - 1);
                    end
                    if (div | divu) begin
                        busy_nx = 1'b1;
                        if (b == 32'h0) begin
                            state_nx = FIX;
                            op_a_nx  = DIV0_QUOT;
                            rem_nx   = a;
                            qneg_nx  = 1'b0;
                            rneg_nx  = 1'b0;
                        end else begin
                            // Magnitudes go through the unsigned datapath; 2^31 stays representable.
                            state_nx = DIV;
                            op_a_nx  = (div & a[31]) ? -a : a;
                            op_b_nx  = (div & b[31]) ? -b : b;
                            rem_nx   = 32'h0;
                            qneg_nx  = div & (a[31] ^ b[31]);
                            rneg_nx  = div & a[31];
                            cnt_nx   = CNT_W'(DIV_ITERS - 1);
                        end
                    end
                end
            end
            MUL: begin
                if (cnt == '0) begin
                    {hi_nx, lo_nx} = product;
                    busy_nx        = 1'b0;
                    state_nx       = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DIV: begin
                rem_nx  = step_rem;
                op_a_nx = step_quot;
                if (cnt == '0) state_nx = FIX;
                else           cnt_nx   = cnt - 1'b1;
            end
            FIX: begin
                lo_nx    = qneg ? -op_a : op_a;
                hi_nx    = rneg ? -rem : rem;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_a       <= 32'h0;
            op_b       <= 32'h0;
            rem        <= 32'h0;
            hi         <= 32'h0;
            lo         <= 32'h0;
            busy       <= 1'b0;
            mul_signed <= 1'b0;
            qneg       <= 1'b0;
            rneg       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            op_a       <= op_a_nx;
            op_b       <= op_b_nx;
            rem        <= rem_nx;
            hi         <= hi_nx;
            lo         <= lo_nx;
            busy       <= busy_nx;
            mul_signed <= mul_signed_nx;
            qneg       <= qneg_nx;
            rneg       <= rneg_nx;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: a plain-arithmetic HI/LO model queues expected
// results and read data; a monitor pops them when busy falls or a read is accepted.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 3;

    typedef enum int {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO} op_e;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          done_edge;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        mult = 1'b0, multu = 1'b0, div = 1'b0, divu = 1'b0;
    logic        mthi = 1'b0, mtlo = 1'b0, mfhi = 1'b0, mflo = 1'b0;
    logic [31:0] a = 32'h0, b = 32'h0;
    logic [31:0] rdata, hi, lo;
    logic        busy, stall;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    res_t        res_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
    int          busy_start = 0, busy_end = 0;
    logic        prev_busy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mult  (mult),
        .multu (multu),
        .div   (div),
        .divu  (divu),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .mfhi  (mfhi),
        .mflo  (mflo),
        .a     (a),
        .b     (b),
        .rdata (rdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .stall (stall)
    );

    always @(negedge clk)
        assert ($onehot0({mult, multu, div, divu, mthi, mtlo, mfhi, mflo}))
            else $error("[TB] decode inputs not one-hot");

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setOp(input op_e op, input bit on);
        logic [7:0] sel;
        sel = on ? (8'h80 >> int'(op)) : 8'h00;
        {mult, multu, div, divu, mthi, mtlo, mfhi, mflo} = sel;
    endtask

    // Architectural model: HI/LO take the final result at acceptance, because every
    // later HI/LO access is stalled until the hardware has caught up.
    function automatic void model(input op_e op, input logic [31:0] x, input logic [31:0] y, input int n);
        longint      sx, sy, q, r, p;
        logic [63:0] pu;
        int          lat;
        lat = 0;
        case (op)
            OP_MULT: begin
                p = longint'(signed'(x)) * longint'(signed'(y));
                m_hi = p[63:32]; m_lo = p[31:0]; lat = MUL_LAT;
            end
            OP_MULTU: begin
                pu = {32'h0, x} * {32'h0, y};
                m_hi = pu[63:32]; m_lo = pu[31:0]; lat = MUL_LAT;
            end
            OP_DIV, OP_DIVU: begin
                if (y == 32'h0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = x; lat = 1;
                end else if (op == OP_DIV) begin
                    sx = longint'(signed'(x)); sy = longint'(signed'(y));
                    q = sx / sy; r = sx % sy;
                    m_lo = q[31:0]; m_hi = r[31:0]; lat = 33;
                end else begin
                    m_lo = x / y; m_hi = x % y; lat = 33;
                end
            end
            OP_MTHI: m_hi = x;
            OP_MTLO: m_lo = x;
            OP_MFHI: rd_q.push_back(m_hi);
            OP_MFLO: rd_q.push_back(m_lo);
            default: ;
        endcase
        if (lat > 0) begin
            res_q.push_back('{hi: m_hi, lo: m_lo, done_edge: n + lat});
            busy_start = n;
            busy_end   = n + lat;
        end
    endfunction

    // Present one op with en=1 until it is no longer stalled; returns #1 after its accept edge.
    task automatic applyStimulus(input op_e op, input logic [31:0] x, input logic [31:0] y);
        int waited;
        waited = 0;
        a = x; b = y; en = 1'b1; setOp(op, 1'b1);
        while (1) begin
            @(negedge clk);
            checkOutput("stall", {63'h0, stall}, {63'h0, (cyc >= busy_start && cyc < busy_end)});
            if (!stall) break;
            waited++;
            if (waited > 100) begin
                total++; bad++;
                $display("[TB] FAIL stall_timeout: still stalled after %0d cycles, expected release", waited);
                break;
            end
        end
        model(op, x, y, cyc + 1);
        @(posedge clk); #1;
        en = 1'b0; setOp(op, 1'b0);
    endtask

    always begin
        res_t r;
        @(negedge clk); #1;
        if (!rst) begin
            prev_busy = 1'b0;
        end else begin
            if (en && (mfhi || mflo) && !stall) begin
                if (rd_q.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL rdata_unexpected: got %0h expected no read", rdata);
                end else begin
                    checkOutput("rdata", {32'h0, rdata}, {32'h0, rd_q.pop_front()});
                end
            end
            if (prev_busy && !busy) begin
                if (res_q.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL done_unexpected: busy fell at cycle %0d expected no op", cyc);
                end else begin
                    r = res_q.pop_front();
                    checkOutput("hi", {32'h0, hi}, {32'h0, r.hi});
                    checkOutput("lo", {32'h0, lo}, {32'h0, r.lo});
                    checkOutput("done_edge", 64'(cyc), 64'(r.done_edge));
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        logic [31:0] x, y;
        op_e         op;
        int          w;

        #12;
        checkOutput("reset_busy", {63'h0, busy}, 64'h0);
        checkOutput("reset_hi", {32'h0, hi}, 64'h0);
        checkOutput("reset_lo", {32'h0, lo}, 64'h0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        applyStimulus(OP_MFHI, 32'h0, 32'h0);
        applyStimulus(OP_MFLO, 32'h0, 32'h0);
        applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        applyStimulus(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        applyStimulus(OP_DIVU, 32'h1234, 32'h0);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        // An unrelated instruction under a divide must not stall; the mflo after it must.
        applyStimulus(OP_DIV, 32'd1000, 32'd3);
        en = 1'b1;
        @(negedge clk);
        checkOutput("stall_no_touch", {63'h0, stall}, 64'h0);
        checkOutput("busy_under_div", {63'h0, busy}, 64'h1);
        @(posedge clk); #1;
        en = 1'b0;
        applyStimulus(OP_MFLO, 32'h0, 32'h0);

        applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        checkOutput("hi_after_mthi", {32'h0, hi}, 64'hDEAD_BEEF);
        applyStimulus(OP_MFHI, 32'h0, 32'h0);

        applyStimulus(OP_MULT, 32'd5, 32'd7);
        applyStimulus(OP_MTLO, 32'h0000_CAFE, 32'h0);
        checkOutput("lo_after_mtlo", {32'h0, lo}, 64'hCAFE);
        applyStimulus(OP_MFLO, 32'h0, 32'h0);

        // Decode held with en=0 is never accepted.
        a = 32'h1111_1111; mthi = 1'b1; en = 1'b0;
        @(negedge clk);
        checkOutput("stall_en_low", {63'h0, stall}, 64'h0);
        @(posedge clk); #1;
        checkOutput("hi_en_low", {32'h0, hi}, {32'h0, m_hi});
        mthi = 1'b0;

        for (int i = 0; i < 40; i++) begin
            op = op_e'($urandom_range(0, 7));
            x  = $urandom;
            y  = $urandom;
            if ($urandom_range(0, 3) == 0) y = y & 32'h0000_00FF;
            if ($urandom_range(0, 7) == 0) y = 32'h0;
            applyStimulus(op, x, y);
        end

        // Asynchronous reset in the middle of a divide discards it.
        applyStimulus(OP_DIV, 32'd12345, 32'd67);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("midreset_busy", {63'h0, busy}, 64'h0);
        checkOutput("midreset_hi", {32'h0, hi}, 64'h0);
        checkOutput("midreset_lo", {32'h0, lo}, 64'h0);
        res_q.delete();
        m_hi = 32'h0; m_lo = 32'h0; busy_end = 0;
        @(negedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(OP_MFLO, 32'h0, 32'h0);
        applyStimulus(OP_MULTU, 32'd6, 32'd9);
        applyStimulus(OP_MFLO, 32'h0, 32'h0);

        w = 0;
        while ((res_q.size() != 0 || rd_q.size() != 0) && w < 100) begin
            @(posedge clk);
            w++;
        end
        checkOutput("res_q_drained", 64'(res_q.size()), 64'h0);
        checkOutput("rd_q_drained", 64'(rd_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
